// File: rtl/uart_tx.sv
// Byte-serial 8N1 UART transmitter fed from a small holding FIFO.
// Latency: a byte accepted into an empty FIFO while idle starts its start bit one cycle later.
// Backpressure: din_ready drops while the FIFO holds FIFO_DEPTH bytes; din_valid is ignored then.

// Generic synchronous FIFO used as the transmitter's holding buffer.
// Latency: pop_dat shows the head combinationally; count updates on the edge after push/pop.
// Backpressure: push is ignored when full and pop is ignored when empty.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int              BW        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;

  logic          push;
  logic          pop;
  logic          bit_end;
  logic [7:0]    head;
  logic          fifo_full;
  logic          fifo_empty;

  assign din_ready = !fifo_full;
  assign push      = din_valid && din_ready;
  assign bit_end   = (baud_cnt == '0);
  // Pop either from idle or exactly at the end of a stop bit, so frames chain without a gap.
  assign pop       = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (din),
    .pop      (pop),
    .pop_dat  (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Frame sequencer: all line-side outputs are registered here so tx never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (pop) begin
            shift_reg <= head;
            baud_cnt  <= BAUD_LAST;
            state     <= START;
            tx        <= 1'b0;
            busy      <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= '0;
            state    <= DATA;
            tx       <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt  <= BAUD_LAST;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              // Next bit is the one that becomes shift_reg[0] after this shift.
              tx      <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            tx_done <= 1'b1;
            if (pop) begin
              shift_reg <= head;
              baud_cnt  <= BAUD_LAST;
              state     <= START;
              tx        <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: default-parameter instance checked by a frame-level scoreboard,
// plus a CLKS_PER_BIT=1 instance checked against the expected serial waveform.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_uart_tx;
  localparam int C = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  logic [7:0] din1 = 8'h00;
  logic       din1_valid = 1'b0;
  logic       din1_ready;
  logic       tx1;
  logic       busy1;
  logic       done1;
  logic [1:0] count1;

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(2)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .din        (din1),
    .din_valid  (din1_valid),
    .din_ready  (din1_ready),
    .tx         (tx1),
    .busy       (busy1),
    .tx_done    (done1),
    .fifo_count (count1)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy plus the remaining length of the frame on the line.
  // A byte leaves the queue when the line is free or the current frame is in its last cycle.
  int         m_count = 0;
  int         m_left  = 0;
  logic       m_push;
  logic       m_pop;
  logic [7:0] exp_q[$];

  assign m_push = din_valid && (m_count != D);
  assign m_pop  = (m_count != 0) && (m_left <= 1);

  always @(posedge clk) begin
    if (reset) begin
      m_count <= 0;
      m_left  <= 0;
      exp_q.delete();
    end else begin
      if (m_push) exp_q.push_back(din);
      m_count <= m_count + int'(m_push) - int'(m_pop);
      if (m_pop) m_left <= 10 * C;
      else if (m_left != 0) m_left <= m_left - 1;
    end
  end

  // Monitor: per-cycle status checks and frame decoding into the scoreboard.
  int         ncyc = 0;
  int         fcyc = 0;
  int         frames_done = 0;
  bit         in_frame = 1'b0;
  bit         pend_done = 1'b0;
  logic       lev [10];
  logic [7:0] got;
  int         start_times[$];
  int         done_times[$];

  always @(negedge clk) begin
    ncyc++;
    if (reset) begin
      in_frame  = 1'b0;
      pend_done = 1'b0;
    end else begin
      chk("tx_done", int'(tx_done), int'(pend_done));
      if (pend_done) done_times.push_back(ncyc);
      pend_done = 1'b0;
      chk("din_ready", int'(din_ready), int'(m_count != D));
      chk("fifo_count", int'(fifo_count), m_count);
      chk("busy", int'(busy), int'(m_left != 0));
      if (m_left == 0) chk("tx_idle", int'(tx), 1);
      if (m_left == 10 * C) chk("tx_start", int'(tx), 0);
      if (!in_frame && tx == 1'b0) begin
        in_frame = 1'b1;
        fcyc = 0;
        start_times.push_back(ncyc);
      end
      if (in_frame) begin
        if (fcyc % C == 0) lev[fcyc / C] = tx;
        else chk("bit_hold", int'(tx), int'(lev[fcyc / C]));
        fcyc++;
        if (fcyc == 10 * C) begin
          in_frame  = 1'b0;
          pend_done = 1'b1;
          frames_done++;
          for (int k = 0; k < 8; k++) got[k] = lev[k + 1];
          chk("start_bit", int'(lev[0]), 0);
          chk("stop_bit", int'(lev[9]), 1);
          if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_frame: got byte %0d, expected no frame", got);
          end else begin
            chk("byte", int'(got), int'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  int last_acc_cyc = 0;

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    din       = b;
    din_valid = 1'b1;
    for (int t = 0; t < 400 && !acc; t++) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      vecs++;
      errs++;
      $display("FAIL accept_timeout: byte %0d not accepted, expected acceptance", b);
    end
    din_valid    = 1'b0;
    last_acc_cyc = ncyc;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = (m_left == 0) && (m_count == 0);
    end
    if (!ok) begin
      vecs++;
      errs++;
      $display("FAIL idle_timeout: count %0d, expected drain to 0", fifo_count);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] burst [6];
  logic [9:0] wave;
  int         n;
  int         s;
  int         fd;
  int         sz;
  int         nacc;
  bit         acc;
  bit         drop_seen;

  initial begin
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55;
    burst[3] = 8'hAA; burst[4] = 8'h01; burst[5] = 8'h80;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(tx_done), 0);
    chk("reset_count", int'(fifo_count), 0);
    chk("reset_ready", int'(din_ready), 1);
    @(posedge clk);
    #1;

    // Single byte.
    send_byte(8'hA5);
    wait_idle();

    // Idle gap between two bytes.
    send_byte(8'h3A);
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    n = start_times.size();
    send_byte(8'hC3);
    for (int t = 0; t < 10 && start_times.size() <= n; t++) @(negedge clk);
    if (start_times.size() > n) chk("gap_start_latency", start_times[n] - last_acc_cyc, 2);
    else chk("gap_start_seen", start_times.size(), n + 1);
    wait_idle();

    // Burst of six bytes with din_valid held high.
    n  = start_times.size();
    fd = frames_done;
    nacc = 0;
    drop_seen = 1'b0;
    din = burst[0];
    din_valid = 1'b1;
    for (int t = 0; t < 2000 && nacc < 6; t++) begin
      @(negedge clk);
      acc = din_ready;
      if (!din_ready && !drop_seen) begin
        drop_seen = 1'b1;
        chk("accepted_before_ready_drop", nacc, 5);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        nacc++;
        if (nacc < 6) din = burst[nacc];
      end
    end
    din_valid = 1'b0;
    chk("burst_accepted", nacc, 6);
    wait_idle();
    chk("burst_frames", frames_done - fd, 6);
    if (start_times.size() > n && done_times.size() > 0)
      chk("burst_span", done_times[$] - start_times[n], 60 * C);
    else
      chk("burst_starts_seen", start_times.size(), n + 6);
    chk("burst_final_count", int'(fifo_count), 0);

    // Full FIFO: a byte offered while full must be dropped.
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    din = 8'h3C;
    din_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("full_count", int'(fifo_count), 4);
      chk("full_ready", int'(din_ready), 0);
    end
    @(posedge clk);
    #1 din_valid = 1'b0;
    wait_idle();

    // Reset during data bit 3 with two bytes queued.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    s = (start_times.size() > 0) ? start_times[$] : ncyc;
    for (int t = 0; t < 200 && ncyc < s + 4 * C + 1; t++) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_tx", int'(tx), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(fifo_count), 0);
    chk("abort_done", int'(tx_done), 0);
    fd = frames_done;
    sz = start_times.size();
    repeat (100) @(negedge clk);
    chk("frames_after_reset", frames_done, fd);
    chk("starts_after_reset", start_times.size(), sz);
    @(posedge clk);
    #1;

    // Randomised traffic.
    for (int t = 0; t < 800; t++) begin
      din_valid = ($urandom_range(0, 3) == 0);
      din = 8'($urandom);
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    wait_idle();
    chk("scoreboard_empty", exp_q.size(), 0);

    // One clock per bit: 0x96 must appear as a 10-cycle frame.
    din1 = 8'h96;
    wave = {1'b1, din1, 1'b0};
    din1_valid = 1'b1;
    @(negedge clk);
    chk("c1_ready", int'(din1_ready), 1);
    @(posedge clk);
    #1 din1_valid = 1'b0;
    @(negedge clk);
    chk("c1_accept_tx", int'(tx1), 1);
    chk("c1_accept_count", int'(count1), 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("c1_tx_cycle%0d", k), int'(tx1), int'(wave[k]));
      chk($sformatf("c1_done_cycle%0d", k), int'(done1), 0);
      chk($sformatf("c1_busy_cycle%0d", k), int'(busy1), 1);
    end
    @(negedge clk);
    chk("c1_done_cycle10", int'(done1), 1);
    chk("c1_tx_cycle10", int'(tx1), 1);
    chk("c1_busy_cycle10", int'(busy1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
